// File: rtl/scan_pkg.sv
// Shared state encoding, default timing constants and small helpers for the
// four-channel excite/blank/sample scan controller.
package scan_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SELECT    = 3'd1;
  localparam logic [2:0] ST_EXCITE    = 3'd2;
  localparam logic [2:0] ST_BLANK     = 3'd3;
  localparam logic [2:0] ST_SAMPLE    = 3'd4;
  localparam logic [2:0] ST_WAIT_CORR = 3'd5;
  localparam logic [2:0] ST_NEXT      = 3'd6;
  localparam logic [2:0] ST_DONE      = 3'd7;

  localparam int NUM_CH           = 4;
  localparam int DEF_SETTLE_CYC   = 500;
  localparam int DEF_PULSE_CYC    = 25;
  localparam int DEF_BLANK_CYC    = 150000;
  localparam int DEF_SAMPLE_DIV   = 50;
  localparam int DEF_N_SAMPLES    = 5000;
  localparam int DEF_CORR_TIMEOUT = 1000000;

  typedef logic [NUM_CH-1:0] ch_mask_t;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/channel_scan_ctrl_if.sv
// Command, ADC, correlator and status signals of the channel scan controller.
interface channel_scan_ctrl_if;
  import scan_pkg::*;

  logic        scan_start;
  logic        scan_abort;
  ch_mask_t    ch_enable;
  logic        adc_req;
  logic        adc_done;
  logic        exc_pulse;
  logic        relay;
  logic [3:0]  vin_sel;
  logic [1:0]  ch_idx;
  logic        corr_start;
  logic        corr_done;
  logic [15:0] sample_cnt;
  logic        busy;
  logic        scan_done;
  logic        err_overrun;
  logic        err_timeout;

  modport master (
    output scan_start, scan_abort, ch_enable, adc_done, corr_done,
    input  adc_req, exc_pulse, relay, vin_sel, ch_idx, corr_start,
           sample_cnt, busy, scan_done, err_overrun, err_timeout
  );

  modport slave (
    input  scan_start, scan_abort, ch_enable, adc_done, corr_done,
    output adc_req, exc_pulse, relay, vin_sel, ch_idx, corr_start,
           sample_cnt, busy, scan_done, err_overrun, err_timeout
  );

endinterface

// File: rtl/sample_tick_gen.sv
// ADC conversion request generator: one request every SAMPLE_DIV clocks while
// enabled, at most N_SAMPLES per window, flagging requests issued while busy.
module sample_tick_gen #(
  parameter int SAMPLE_DIV = 50,
  parameter int N_SAMPLES  = 5000
) (
  input  logic clk_50M,
  input  logic rst_n,
  input  logic en,
  input  logic done,
  output logic req,
  output logic overrun
);

  localparam int DIV_W = $clog2(SAMPLE_DIV + 1);
  localparam int REQ_W = $clog2(N_SAMPLES + 1);

  logic [DIV_W-1:0] div_cnt;
  logic [REQ_W-1:0] req_cnt;
  logic             pending;

  assign req     = en && (div_cnt == '0) && (req_cnt != REQ_W'(N_SAMPLES));
  // A strobe landing in the same cycle the next request falls due is on time.
  assign overrun = req && pending && !done;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      req_cnt <= '0;
      pending <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      req_cnt <= '0;
      pending <= 1'b0;
    end else begin
      div_cnt <= (div_cnt == '0) ? DIV_W'(SAMPLE_DIV - 1) : div_cnt - DIV_W'(1);
      if (req) begin
        req_cnt <= req_cnt + REQ_W'(1);
        pending <= 1'b1;
      end else if (done) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/channel_scan_ctrl.sv
// Four-channel transducer scan: select, excite, blank, sample, correlate,
// then advance to the next enabled channel without wrapping.
//
// state      | meaning
// IDLE       | waiting for scan_start
// NEXT       | pick lowest enabled channel at/above search pointer
// SELECT     | mux settling on the chosen channel
// EXCITE     | excitation pulse, relay in transmit
// BLANK      | ring-down blanking, relay still protecting
// SAMPLE     | relay receive, paced ADC conversions
// WAIT_CORR  | correlator running, bounded by CORR_TIMEOUT
// DONE       | one-cycle scan_done
module channel_scan_ctrl
  import scan_pkg::*;
#(
  parameter int SETTLE_CYC   = DEF_SETTLE_CYC,
  parameter int PULSE_CYC    = DEF_PULSE_CYC,
  parameter int BLANK_CYC    = DEF_BLANK_CYC,
  parameter int SAMPLE_DIV   = DEF_SAMPLE_DIV,
  parameter int N_SAMPLES    = DEF_N_SAMPLES,
  parameter int CORR_TIMEOUT = DEF_CORR_TIMEOUT
) (
  input logic                clk_50M,
  input logic                rst_n,
  channel_scan_ctrl_if.slave bus
);

  localparam int TMR_MAX = max_of(max_of(SETTLE_CYC, PULSE_CYC), max_of(BLANK_CYC, CORR_TIMEOUT));
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int CNT_W   = $clog2(N_SAMPLES + 1);

  logic [2:0]       state;
  ch_mask_t         mask;
  logic [2:0]       ptr;
  logic [TMR_W-1:0] timer;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       ch_idx;
  logic [3:0]       vin_sel;
  logic             corr_start;
  logic             err_overrun;
  logic             err_timeout;
  logic             tick;
  logic             overrun;
  logic             found;
  logic [1:0]       next_ch;

  sample_tick_gen #(
    .SAMPLE_DIV (SAMPLE_DIV),
    .N_SAMPLES  (N_SAMPLES)
  ) u_tick (
    .clk_50M (clk_50M),
    .rst_n   (rst_n),
    .en      (state == ST_SAMPLE),
    .done    (bus.adc_done),
    .req     (tick),
    .overrun (overrun)
  );

  // Descending scan so the last hit is the lowest enabled index >= ptr.
  always_comb begin
    found   = 1'b0;
    next_ch = 2'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= ptr)) begin
        found   = 1'b1;
        next_ch = 2'(i);
      end
    end
  end

  assign bus.busy        = (state != ST_IDLE);
  assign bus.exc_pulse   = (state == ST_EXCITE);
  assign bus.relay       = (state == ST_EXCITE) || (state == ST_BLANK);
  assign bus.adc_req     = tick;
  assign bus.scan_done   = (state == ST_DONE);
  assign bus.corr_start  = corr_start;
  assign bus.ch_idx      = ch_idx;
  assign bus.vin_sel     = vin_sel;
  assign bus.sample_cnt  = 16'(cnt);
  assign bus.err_overrun = err_overrun;
  assign bus.err_timeout = err_timeout;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      mask        <= '0;
      ptr         <= '0;
      timer       <= '0;
      cnt         <= '0;
      ch_idx      <= '0;
      vin_sel     <= '0;
      corr_start  <= 1'b0;
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      corr_start <= 1'b0;
      if (overrun) err_overrun <= 1'b1;
      if (bus.scan_abort) begin
        state   <= ST_IDLE;
        vin_sel <= '0;
      end else begin
        case (state)
          ST_IDLE: if (bus.scan_start) begin
            mask        <= bus.ch_enable;
            ptr         <= '0;
            cnt         <= '0;
            err_overrun <= 1'b0;
            err_timeout <= 1'b0;
            state       <= ST_NEXT;
          end
          ST_NEXT: if (found) begin
            ch_idx  <= next_ch;
            vin_sel <= 4'b0001 << next_ch;
            timer   <= TMR_W'(SETTLE_CYC - 1);
            state   <= ST_SELECT;
          end else begin
            state <= ST_DONE;
          end
          ST_SELECT: if (timer == '0) begin
            timer <= TMR_W'(PULSE_CYC - 1);
            state <= ST_EXCITE;
          end else begin
            timer <= timer - TMR_W'(1);
          end
          ST_EXCITE: if (timer == '0) begin
            timer <= TMR_W'(BLANK_CYC - 1);
            state <= ST_BLANK;
          end else begin
            timer <= timer - TMR_W'(1);
          end
          ST_BLANK: if (timer == '0) begin
            cnt   <= '0;
            state <= ST_SAMPLE;
          end else begin
            timer <= timer - TMR_W'(1);
          end
          ST_SAMPLE: if (cnt == CNT_W'(N_SAMPLES)) begin
            corr_start <= 1'b1;
            timer      <= TMR_W'(CORR_TIMEOUT - 1);
            state      <= ST_WAIT_CORR;
          end else if (bus.adc_done) begin
            cnt <= cnt + CNT_W'(1);
          end
          ST_WAIT_CORR: if (bus.corr_done || (timer == '0)) begin
            if (!bus.corr_done) err_timeout <= 1'b1;
            ptr   <= {1'b0, ch_idx} + 3'd1;
            state <= ST_NEXT;
          end else begin
            timer <= timer - TMR_W'(1);
          end
          ST_DONE: begin
            vin_sel <= '0;
            state   <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_channel_scan_ctrl.sv
// Scoreboard bench for channel_scan_ctrl with small timing parameters, an ADC
// responder with programmable latency and a correlator that can be muted.
module tb_channel_scan_ctrl;

  localparam int SETTLE = 4;
  localparam int PULSE  = 3;
  localparam int BLANK  = 5;
  localparam int DIV    = 10;
  localparam int NS     = 4;
  localparam int TMO    = 100;

  logic clk_50M = 1'b0;
  logic rst_n   = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  channel_scan_ctrl_if bus();

  channel_scan_ctrl #(
    .SETTLE_CYC   (SETTLE),
    .PULSE_CYC    (PULSE),
    .BLANK_CYC    (BLANK),
    .SAMPLE_DIV   (DIV),
    .N_SAMPLES    (NS),
    .CORR_TIMEOUT (TMO)
  ) dut (
    .clk_50M (clk_50M),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #10 clk_50M = ~clk_50M;
  always @(posedge clk_50M) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // ADC and correlator responders
  int adc_lat = 3;
  bit corr_en = 1'b1;
  int adc_due[$];
  int corr_due[$];

  always @(negedge clk_50M) begin
    bus.adc_done  = 1'b0;
    bus.corr_done = 1'b0;
    if (adc_due.size() > 0 && adc_due[0] == cyc) begin
      void'(adc_due.pop_front());
      bus.adc_done = 1'b1;
    end
    if (corr_due.size() > 0 && corr_due[0] == cyc) begin
      void'(corr_due.pop_front());
      bus.corr_done = 1'b1;
    end
    if (rst_n && bus.adc_req) adc_due.push_back(cyc + adc_lat);
    if (rst_n && bus.corr_start && corr_en) corr_due.push_back(cyc + 20);
  end

  // Monitor / scoreboard
  int   exp_ch[$];
  bit   mon_en = 1'b1;
  logic exc_d  = 1'b0;
  int   exc_w, req_n, last_req, e;
  int   n_exc, n_req, n_done, done_cyc, n_corr, corr_cyc, corr_gap;
  int   start_cyc;

  always @(negedge clk_50M) begin
    if (rst_n) begin
      if (bus.exc_pulse && !exc_d) begin
        n_exc++;
        req_n = 0;
        exc_w = 0;
        if (mon_en) begin
          chk("exc_expected", exp_ch.size() > 0, 1);
          if (exp_ch.size() > 0) begin
            e = exp_ch.pop_front();
            chk("ch_idx", bus.ch_idx, e);
            chk("vin_sel", bus.vin_sel, 1 << e);
            chk("relay_exc", bus.relay, 1);
          end
        end
      end
      if (bus.exc_pulse) exc_w++;
      if (!bus.exc_pulse && exc_d && mon_en) chk("exc_width", exc_w, PULSE);
      if (bus.adc_req) begin
        n_req++;
        if (mon_en) begin
          chk("relay_sample", bus.relay, 0);
          if (req_n > 0) chk("req_gap", cyc - last_req, DIV);
        end
        req_n++;
        last_req = cyc;
      end
      if (bus.corr_start) begin
        if (mon_en) begin
          chk("req_per_ch", req_n, NS);
          chk("sample_cnt", bus.sample_cnt, NS);
        end
        if (n_corr > 0) corr_gap = cyc - corr_cyc;
        n_corr++;
        corr_cyc = cyc;
      end
      if (bus.scan_done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
    exc_d = bus.exc_pulse;
  end

  task automatic start_scan(input logic [3:0] m);
    exp_ch.delete();
    adc_due.delete();
    corr_due.delete();
    for (int i = 0; i < 4; i++) if (m[i]) exp_ch.push_back(i);
    @(negedge clk_50M);
    bus.ch_enable  = m;
    bus.scan_start = 1'b1;
    start_cyc      = cyc;
    @(negedge clk_50M);
    bus.scan_start = 1'b0;
    bus.ch_enable  = 4'b0000;
  endtask

  task automatic wait_done(input int prev, input int limit, input string tag);
    int k = 0;
    while (n_done == prev && k < limit) begin
      @(negedge clk_50M);
      k++;
    end
    @(negedge clk_50M);
    chk(tag, n_done, prev + 1);
  endtask

  int p_done, p_exc, p_req, p_corr, k;

  initial begin
    bus.scan_start = 1'b0;
    bus.scan_abort = 1'b0;
    bus.ch_enable  = 4'b0000;
    bus.adc_done   = 1'b0;
    bus.corr_done  = 1'b0;

    repeat (3) @(negedge clk_50M);
    chk("rst_busy", bus.busy, 0);
    chk("rst_relay", bus.relay, 0);
    chk("rst_vin_sel", bus.vin_sel, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_50M);
    chk("idle_busy", bus.busy, 0);
    chk("idle_scan_done", n_done, 0);

    // all four channels, prompt ADC and correlator
    p_done = n_done; p_exc = n_exc; p_req = n_req;
    start_scan(4'b1111);
    wait_done(p_done, 2000, "s1111_done");
    repeat (5) @(negedge clk_50M);
    chk("s1111_one_done", n_done, p_done + 1);
    chk("s1111_all_excited", exp_ch.size(), 0);
    chk("s1111_exc_count", n_exc - p_exc, 4);
    chk("s1111_req_count", n_req - p_req, 16);
    chk("s1111_overrun", bus.err_overrun, 0);
    chk("s1111_timeout", bus.err_timeout, 0);
    chk("s1111_busy_after", bus.busy, 0);

    // channels 1 and 3; a second start while busy must be ignored
    p_done = n_done; p_exc = n_exc;
    start_scan(4'b1010);
    repeat (10) @(negedge clk_50M);
    bus.ch_enable = 4'b1111; bus.scan_start = 1'b1;
    @(negedge clk_50M);
    bus.scan_start = 1'b0; bus.ch_enable = 4'b0000;
    wait_done(p_done, 2000, "s1010_done");
    chk("s1010_exc_count", n_exc - p_exc, 2);
    chk("s1010_all_excited", exp_ch.size(), 0);

    // empty mask
    p_done = n_done; p_exc = n_exc; p_req = n_req;
    start_scan(4'b0000);
    wait_done(p_done, 20, "s0000_done");
    chk("s0000_latency", done_cyc - start_cyc, 2);
    chk("s0000_no_exc", n_exc - p_exc, 0);
    chk("s0000_no_req", n_req - p_req, 0);

    // slow ADC: overrun but scan completes
    adc_lat = 12;
    p_done = n_done;
    start_scan(4'b0011);
    wait_done(p_done, 2000, "slow_adc_done");
    chk("slow_adc_overrun", bus.err_overrun, 1);
    chk("slow_adc_timeout", bus.err_timeout, 0);
    adc_lat = 3;

    // mute correlator: timeout on each channel
    corr_en = 1'b0;
    p_done = n_done; p_corr = n_corr;
    start_scan(4'b0011);
    wait_done(p_done, 3000, "tmo_done");
    chk("tmo_flag", bus.err_timeout, 1);
    chk("tmo_overrun_cleared", bus.err_overrun, 0);
    chk("tmo_corr_starts", n_corr - p_corr, 2);
    chk("tmo_gap_min", corr_gap >= TMO, 1);
    chk("tmo_gap_max", corr_gap <= TMO + 60, 1);
    corr_en = 1'b1;

    // abort during EXCITE
    mon_en = 1'b0;
    start_scan(4'b1111);
    k = 0;
    while (!bus.exc_pulse && k < 100) begin @(negedge clk_50M); k++; end
    chk("abort_reach_excite", bus.exc_pulse, 1);
    p_done = n_done;
    bus.scan_abort = 1'b1;
    @(negedge clk_50M);
    bus.scan_abort = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_exc", bus.exc_pulse, 0);
    chk("abort_relay", bus.relay, 0);
    repeat (50) @(negedge clk_50M);
    chk("abort_no_done", n_done, p_done);
    chk("abort_stays_idle", bus.busy, 0);

    // reset during SAMPLE
    start_scan(4'b1111);
    k = 0;
    while (!bus.adc_req && k < 200) begin @(negedge clk_50M); k++; end
    chk("rst_reach_sample", bus.adc_req, 1);
    p_done = n_done;
    rst_n = 1'b0;
    @(negedge clk_50M);
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_exc", bus.exc_pulse, 0);
    chk("rst_mid_relay", bus.relay, 0);
    chk("rst_mid_adc_req", bus.adc_req, 0);
    chk("rst_mid_sample_cnt", bus.sample_cnt, 0);
    chk("rst_mid_vin_sel", bus.vin_sel, 0);
    rst_n = 1'b1;
    repeat (60) @(negedge clk_50M);
    chk("rst_no_done", n_done, p_done);
    chk("rst_no_restart", bus.busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/channel_scan_ctrl.md
CHANNEL_SCAN_CTRL -- requirements
Module: channel_scan_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  SETTLE_CYC 500: clocks of mux settling after a channel switch.
  PULSE_CYC 25: excitation pulse width in clocks.
  BLANK_CYC 150000: blanking clocks after the pulse.
  SAMPLE_DIV 50: clocks per ADC conversion request (1 MHz at 50 MHz).
  N_SAMPLES 5000: conversions per channel window.
  CORR_TIMEOUT 1000000: maximum clocks to wait for corr_done.
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk_50M in 1: system clock; the block uses this single clock.
  rst_n in 1: asynchronous, active-low reset.
  scan_start in 1: single-cycle request to start a four-channel scan.
  scan_abort in 1: single-cycle request to stop immediately.
  ch_enable in 4: channel mask, sampled at scan start.
  adc_req out 1: single-cycle conversion request to the AD7352 interface.
  adc_done in 1: single-cycle conversion-complete strobe (ad_done).
  exc_pulse out 1: transducer excitation drive.
  relay out 1: T/R switch; high means transmit/protect.
  vin_sel out 4: one-hot channel select for VIN_1..VIN_4.
  ch_idx out 2: index of the active channel.
  corr_start out 1: single-cycle start to the echo correlator.
  corr_done in 1: single-cycle correlator-finished strobe.
  sample_cnt out 16: conversions completed in the current window.
  busy out 1: high in every state except IDLE.
  scan_done out 1: single-cycle end-of-scan strobe.
  err_overrun out 1: sticky; adc_done did not arrive before the next request was due.
  err_timeout out 1: sticky; corr_done was not received within CORR_TIMEOUT.

Function
REQ-003 The FSM SHALL have these states: IDLE, SELECT, EXCITE, BLANK, SAMPLE, WAIT_CORR, NEXT, DONE.
REQ-004 IDLE SHALL respond to scan_start as follows:
  - Latch ch_enable and clear both error flags.
  - Go to NEXT with a search starting at channel 0.
  - Ignore scan_start while busy is high.
REQ-005 NEXT SHALL select the lowest enabled channel index at or above the search pointer, then go to SELECT; if none remains, it SHALL go to DONE.
REQ-006 SELECT SHALL drive vin_sel and ch_idx for the chosen channel and hold for SETTLE_CYC clocks, then go to EXCITE.
REQ-007 EXCITE SHALL hold exc_pulse and relay high for exactly PULSE_CYC clocks, then go to BLANK.
REQ-008 BLANK SHALL hold relay high and exc_pulse low for BLANK_CYC clocks, then go to SAMPLE.
REQ-009 SAMPLE SHALL behave as follows:
  - Hold relay low.
  - Issue adc_req on the first SAMPLE cycle and then every SAMPLE_DIV clocks.
  - Increment sample_cnt on each adc_done.
  - Issue no further adc_req once N_SAMPLES requests have been sent.
  - Go to WAIT_CORR when sample_cnt reaches N_SAMPLES.
REQ-010 An adc_req falling due while the previous adc_done is still outstanding SHALL set err_overrun, and the request SHALL be issued anyway.
REQ-011 On entry to WAIT_CORR the block SHALL pulse corr_start for one cycle, then wait for corr_done.
  - On corr_done: set the search pointer to ch_idx+1 and go to NEXT.
  - On CORR_TIMEOUT: set err_timeout and continue as on corr_done.
REQ-012 The search pointer SHALL end the scan when it passes channel 3; it SHALL NOT wrap within a scan.
REQ-013 DONE SHALL pulse scan_done for one cycle and return to IDLE.
REQ-014 A ch_enable of 4'b0000 at start SHALL produce scan_done two cycles after scan_start, with no exc_pulse and no adc_req.
REQ-015 scan_abort SHALL take priority over every other event.
  - The next state is IDLE.
  - exc_pulse, relay, adc_req and corr_start deassert on the next clock.
  - scan_done is not pulsed.
REQ-016 adc_done and corr_done arriving outside SAMPLE and WAIT_CORR respectively SHALL be ignored.
REQ-017 Counter widths SHALL be sized by $clog2 of their parameter, with sample_cnt saturating at N_SAMPLES.

Reset
REQ-018 Assertion of rst_n SHALL, asynchronously:
  - Force the FSM to IDLE.
  - Drive every output to 0.
  - Clear all counters, the latched mask and the sticky flags.
REQ-019 Reset deassertion SHALL take effect synchronously on the next clk_50M rising edge, with no scan starting until a fresh scan_start.

Structure
REQ-020 The state encoding and default timing constants SHALL reside in the shared package scan_pkg.
REQ-021 The SAMPLE_DIV request generator with overrun detection SHALL be the sub-module sample_tick_gen; the channel-search priority logic SHALL stay inline.

Verification
All scenarios use SETTLE_CYC=4, PULSE_CYC=3, BLANK_CYC=5, SAMPLE_DIV=10, N_SAMPLES=4, CORR_TIMEOUT=100.
REQ-022 Scenario: ch_enable=4'b1111, with an ADC model answering 3 clocks after each request and the correlator answering 20 clocks after start.
  - vin_sel steps 0001, 0010, 0100, 1000.
  - exc_pulse is 3 clocks wide per channel.
  - Four adc_req per channel, 10 clocks apart.
  - One scan_done; no error flags set.
REQ-023 Scenario: ch_enable=4'b1010 -> only channels 1 and 3 are excited, and ch_idx shows 1 then 3.
REQ-024 Scenario: ch_enable=4'b0000 -> scan_done occurs 2 cycles after scan_start, with exc_pulse never high.
REQ-025 Scenario: ADC model answers 12 clocks after each request -> err_overrun=1, the scan still completes, and sample_cnt=4 per channel.
REQ-026 Scenario: correlator never answers -> err_timeout=1, and corr_start occurs again for the next channel about 100 clocks later.
REQ-027 Scenario: scan_abort during EXCITE, and separately rst_n low during SAMPLE -> next clock busy=0, exc_pulse=0 and relay=0, and no scan_done occurs.
